// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It samples the rx line through a two-flop
// synchronizer, times each bit with a counter and reports every received byte.
// A good frame gives a one-cycle valid pulse, and data holds that byte until
// the next good frame. A low stop bit gives a one-cycle frame_err pulse.
// Optional build macro UART_RX_MAJORITY_EN: each sample point takes the
// 2-of-3 majority of rx_s around the bit centre instead of a single sample.
// This adds one clock to the valid/frame_err latency.
module uart_rx #(
  parameter int CLKFREQ = 12000000,
  parameter int BAUD    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB  = CLKFREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB) + 1;

  // OFS is the number of clocks between the bit-centre sample and the decision.
  // The timer reloads to OFS, so the bit period stays exactly CPB clocks.
`ifdef UART_RX_MAJORITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  localparam logic [TW-1:0] START_T = TW'(HALF - 1);
  localparam logic [TW-1:0] BIT_T   = TW'(CPB - 1);
  localparam logic [TW-1:0] RELOAD  = TW'(OFS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] tgt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          sync1;
  logic          rx_s;
  logic          hit;
  logic          smp;

  // Two-flop synchronizer; the line idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // The start bit is checked at its half point; every later bit is checked one full bit period after the previous sample.
  always_comb begin
    tgt = (state == S_START) ? START_T : BIT_T;
    hit = (timer == tgt + RELOAD);
  end

`ifdef UART_RX_MAJORITY_EN
  logic m0;
  logic m1;

  // Capture the two samples before the decision cycle; the third sample is the live rx_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= 1'b1;
      m1 <= 1'b1;
    end else begin
      if (timer == tgt - TW'(1)) m0 <= rx_s;
      if (timer == tgt)          m1 <= rx_s;
    end
  end

  // 2-of-3 vote of the samples at centre-1, centre and centre+1.
  always_comb begin
    smp = (m0 & m1) | (m0 & rx_s) | (m1 & rx_s);
  end
`else
  // Single sample at the bit centre.
  always_comb begin
    smp = rx_s;
  end
`endif

  // Receive FSM: detect the start bit, shift in the data bits LSB first, then check the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            timer <= '0;
          end
        end
        S_START: begin
          if (hit) begin
            timer <= RELOAD;
            idx   <= '0;
            // If the line is high again, the low level was only a glitch.
            state <= smp ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DATA: begin
          if (hit) begin
            timer      <= RELOAD;
            shreg[idx] <= smp;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_STOP: begin
          if (hit) begin
            timer <= '0;
            if (smp) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_BREAK: begin
          // Hold here while the line stays low, so a long break reports only one error.
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The receiver is busy in every state except idle.
  always_comb begin
    busy = (state != S_IDLE);
  end

endmodule
